vidaddr: RTL and testbench

Video address counter and fetch requester sitting directly downstream of `gstmcu`. It consumes the timing outputs `de` and `vsync_n` and tracks the current screen word address. It issues one video-word fetch request to the RAM arbiter per 4-clock slot while display is enabled. It also holds the CPU-visible screen base and counter registers.

---
 rtl/vidaddr_if.sv | 47 ++++
 rtl/vidaddr.sv | 228 ++++++++++++++++++++++
 tb/tb_vidaddr.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vidaddr_if.sv
// vidaddr_if: bundles the CPU register-access bus and the video fetch
// request channel of the video address counter.
//   cpu_sel/cpu_we/cpu_a/cpu_di : register access from the CPU side
//   cpu_do                      : registered read data back to the CPU
//   vid_req/vid_addr            : fetch request towards the RAM arbiter
//   vid_ack                     : arbiter acceptance of the request
//   overrun                     : sticky missed-slot flag
// Modports:
//   slave  - the vidaddr block (responds to CPU accesses, raises requests)
//   master - the surrounding system (CPU and RAM arbiter)
interface vidaddr_if #(
    parameter int AW = 21
);
    logic          cpu_sel;
    logic          cpu_we;
    logic [3:0]    cpu_a;
    logic [7:0]    cpu_di;
    logic [7:0]    cpu_do;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          overrun;

    modport slave (
        input  cpu_sel,
        input  cpu_we,
        input  cpu_a,
        input  cpu_di,
        input  vid_ack,
        output cpu_do,
        output vid_req,
        output vid_addr,
        output overrun
    );

    modport master (
        output cpu_sel,
        output cpu_we,
        output cpu_a,
        output cpu_di,
        output vid_ack,
        input  cpu_do,
        input  vid_req,
        input  vid_addr,
        input  overrun
    );
endinterface

// File: rtl/vidaddr.sv
// vidaddr: video word-address counter and fetch requester.
// Tracks the screen word address, reloads it from the CPU-programmed base
// at each vertical sync falling edge, and raises one fetch request per
// 4-clock slot while display is enabled.
// Ports:
//   m2clock  - system clock, all state on rising edge
//   resb     - asynchronous active-low reset
//   de       - display enable from the timing generator
//   vsync_n  - vertical sync (active low) from the timing generator
//   bus      - vidaddr_if.slave: CPU register bus + fetch request channel
// Register map (byte offsets): $1 base[21:16], $3 base[15:8],
//   $5/$7/$9 counter [21:16]/[15:8]/[7:0] (read-only, reading $5 clears
//   overrun), $D base[7:1] and $F line offset (scroll build only).
// Build option: define VIDADDR_STE_SCROLL_EN to enable the writable low
//   base byte and the per-line offset add on the falling edge of de.
// The register map assumes AW = 21 (word address = byte address 21:1).
module vidaddr #(
    parameter int AW = 21
) (
    input  logic     m2clock,
    input  logic     resb,
    input  logic     de,
    input  logic     vsync_n,
    vidaddr_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_n_s;
    logic [1:0]    phase_r;
    logic          vs_r;
    logic          vs_d_r;
    logic [5:0]    base_hi_r;
    logic [7:0]    base_mid_r;
    logic [AW-1:0] counter_r;
    logic [AW-1:0] counter_n_s;
    logic [AW-1:0] vid_addr_r;
    logic [AW-1:0] addr_n_s;
    logic          vid_req_r;
    logic          req_n_s;
    logic          overrun_r;
    logic          overrun_n_s;
    logic [7:0]    cpu_do_r;
    logic [7:0]    rd_data_s;
    logic          slot_s;
    logic          vload_s;
    logic          rd_s;
    logic          wr_s;
    logic          inc_s;
    logic          ovr_set_s;
    logic [6:0]    base_lo_s;
    logic [7:0]    offset_s;
    logic          de_fall_s;
    logic [AW-1:0] base_word_s;

    assign slot_s  = (phase_r == 2'd3) && de;
    // vsync_n is sampled into vs_r; the edge is detected between the two
    // registered copies, so the reload lands two edges after the fall.
    assign vload_s = vs_d_r & ~vs_r;
    assign rd_s    = bus.cpu_sel & ~bus.cpu_we;
    assign wr_s    = bus.cpu_sel & bus.cpu_we;

`ifdef VIDADDR_STE_SCROLL_EN
    logic [6:0] base_lo_r;
    logic [7:0] offset_r;
    logic       de_d_r;

    // Low base byte, line offset and registered de for falling-edge detect
    always_ff @(posedge m2clock or negedge resb) begin
        if (!resb) begin
            base_lo_r <= 7'd0;
            offset_r  <= 8'd0;
            de_d_r    <= 1'b0;
        end else begin
            de_d_r <= de;
            if (wr_s && (bus.cpu_a == 4'hD)) begin
                base_lo_r <= bus.cpu_di[7:1];
            end
            if (wr_s && (bus.cpu_a == 4'hF)) begin
                offset_r <= bus.cpu_di;
            end
        end
    end

    assign base_lo_s = base_lo_r;
    assign offset_s  = offset_r;
    assign de_fall_s = de_d_r & ~de;
`else
    assign base_lo_s = 7'd0;
    assign offset_s  = 8'd0;
    assign de_fall_s = 1'b0;
`endif

    assign base_word_s = AW'({base_hi_r, base_mid_r, base_lo_s});

    // CPU read data multiplexer; unmapped offsets read zero
    always_comb begin
        rd_data_s = 8'h00;
        case (bus.cpu_a)
            4'h1:    rd_data_s = {2'b00, base_hi_r};
            4'h3:    rd_data_s = base_mid_r;
            4'h5:    rd_data_s = {2'b00, counter_r[20:15]};
            4'h7:    rd_data_s = counter_r[14:7];
            4'h9:    rd_data_s = {counter_r[6:0], 1'b0};
            4'hD:    rd_data_s = {base_lo_s, 1'b0};
            4'hF:    rd_data_s = offset_s;
            default: rd_data_s = 8'h00;
        endcase
    end

    // Request FSM next state, request outputs and counter-increment strobe
    always_comb begin
        state_n_s = state_r;
        req_n_s   = vid_req_r;
        addr_n_s  = vid_addr_r;
        inc_s     = 1'b0;
        ovr_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (slot_s) begin
                    state_n_s = PEND;
                    req_n_s   = 1'b1;
                    addr_n_s  = counter_r;
                end else begin
                    req_n_s   = 1'b0;
                end
            end
            PEND: begin
                if (bus.vid_ack) begin
                    inc_s = 1'b1;
                    // A reload coinciding with the ack always ends the request
                    if (slot_s && !vload_s) begin
                        state_n_s = PEND;
                        req_n_s   = 1'b1;
                        addr_n_s  = counter_r + AW'(1'b1);
                    end else begin
                        state_n_s = IDLE;
                        req_n_s   = 1'b0;
                    end
                end else if (slot_s) begin
                    ovr_set_s = 1'b1;
                end else begin
                    ovr_set_s = 1'b0;
                end
            end
            default: begin
                state_n_s = IDLE;
                req_n_s   = 1'b0;
            end
        endcase
    end

    // Counter next value: reload beats increment and line-offset add
    always_comb begin
        counter_n_s = counter_r;
        if (vload_s) begin
            counter_n_s = base_word_s;
        end else begin
            counter_n_s = counter_r
                        + (inc_s ? AW'(1'b1) : AW'(1'b0))
                        + (de_fall_s ? AW'(offset_s) : AW'(1'b0));
        end
    end

    // Sticky overrun: a set in the same cycle beats the clear-on-read of $5
    always_comb begin
        overrun_n_s = overrun_r;
        if (ovr_set_s) begin
            overrun_n_s = 1'b1;
        end else if (rd_s && (bus.cpu_a == 4'h5)) begin
            overrun_n_s = 1'b0;
        end else begin
            overrun_n_s = overrun_r;
        end
    end

    // Slot phase, vsync sampling, FSM state, counter and request outputs
    always_ff @(posedge m2clock or negedge resb) begin
        if (!resb) begin
            phase_r    <= 2'd0;
            vs_r       <= 1'b0;
            vs_d_r     <= 1'b0;
            state_r    <= IDLE;
            vid_req_r  <= 1'b0;
            vid_addr_r <= '0;
            counter_r  <= '0;
            overrun_r  <= 1'b0;
        end else begin
            phase_r    <= phase_r + 2'd1;
            vs_r       <= vsync_n;
            vs_d_r     <= vs_r;
            state_r    <= state_n_s;
            vid_req_r  <= req_n_s;
            vid_addr_r <= addr_n_s;
            counter_r  <= counter_n_s;
            overrun_r  <= overrun_n_s;
        end
    end

    // CPU-visible base registers and registered read data
    always_ff @(posedge m2clock or negedge resb) begin
        if (!resb) begin
            base_hi_r  <= 6'd0;
            base_mid_r <= 8'd0;
            cpu_do_r   <= 8'h00;
        end else begin
            if (wr_s && (bus.cpu_a == 4'h1)) begin
                base_hi_r <= bus.cpu_di[5:0];
            end
            if (wr_s && (bus.cpu_a == 4'h3)) begin
                base_mid_r <= bus.cpu_di;
            end
            if (rd_s) begin
                cpu_do_r <= rd_data_s;
            end
        end
    end

    assign bus.cpu_do   = cpu_do_r;
    assign bus.vid_req  = vid_req_r;
    assign bus.vid_addr = vid_addr_r;
    assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_vidaddr.sv
// tb_vidaddr: directed and randomized bench for vidaddr with a
// transaction-level reference model of the fetch/counter behaviour.
module tb_vidaddr;

    logic clk;
    logic resb;
    logic de;
    logic vsync_n;

    vidaddr_if #(.AW(21)) bus ();

    vidaddr #(.AW(21)) dut (
        .m2clock (clk),
        .resb    (resb),
        .de      (de),
        .vsync_n (vsync_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // bench-side slot phase and reference model state
    logic [1:0]  ph;
    logic        m_pend;
    logic [20:0] m_cnt;
    logic [20:0] m_addr;
    int          m_wait;
    logic        m_ovr;
    logic        m_de_prev;
    logic [7:0]  m_off;
    logic [5:0]  b_hi;
    logic [7:0]  b_mid;
    logic [6:0]  b_lo;
    int          obs_nreq;
    logic        obs_prev_req;
    logic        obs_prev_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (resb) ph = ph + 2'd1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = a; bus.cpu_di = d;
        tick();
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = a;
        tick();
        bus.cpu_sel = 1'b0;
        d = bus.cpu_do;
        if (a == 4'h5) m_ovr = 1'b0;
    endtask

    task automatic set_base(input logic [5:0] hi, input logic [7:0] mid, input logic [6:0] lo);
        wr(4'h1, {2'b00, hi});
        wr(4'h3, mid);
        wr(4'hD, {lo, 1'b0});
        b_hi = hi; b_mid = mid;
`ifdef VIDADDR_STE_SCROLL_EN
        b_lo = lo;
`else
        b_lo = 7'd0;
`endif
    endtask

    // vsync_n low for two edges: counter takes the base at the second edge
    task automatic vpulse();
        vsync_n = 1'b0;
        tick();
        tick();
        vsync_n = 1'b1;
        m_cnt = {b_hi, b_mid, b_lo};
    endtask

    task automatic align0();
        while (ph != 2'd0) tick();
    endtask

    // Reads $5/$7/$9 and compares against the byte image of a word address
    task automatic read_cnt(input string tag, input logic [20:0] exp);
        logic [7:0] h, m, l;
        rd(4'h5, h);
        rd(4'h7, m);
        rd(4'h9, l);
        check(tag, {8'h00, h, m, l}, {8'h00, 2'b00, exp, 1'b0});
    endtask

    // n cycles: de high for the first de_len, arbiter acks after 'delay'
    // waiting cycles of each request; model applies the protocol rules.
    task automatic run(input int n, input int de_len, input int delay);
        obs_prev_req = bus.vid_req;
        obs_prev_ack = 1'b0;
        for (int c = 0; c < n; c++) begin
            logic de_v, ack_v, slot;
            de_v  = (c < de_len);
            ack_v = m_pend && (m_wait == delay);
            de = de_v;
            bus.vid_ack = ack_v;
            slot = (ph == 2'd3) && de_v;
            if (m_pend && ack_v) begin
                m_cnt = m_cnt + 21'd1;
                if (slot) begin
                    m_addr = m_cnt;
                    m_wait = 0;
                end else begin
                    m_pend = 1'b0;
                end
            end else if (m_pend) begin
                if (slot) m_ovr = 1'b1;
                m_wait++;
            end else if (slot) begin
                m_pend = 1'b1;
                m_addr = m_cnt;
                m_wait = 0;
            end
            if (m_de_prev && !de_v) m_cnt = m_cnt + {13'd0, m_off};
            m_de_prev = de_v;
            tick();
            if (bus.vid_req === 1'b1 && (!obs_prev_req || obs_prev_ack)) obs_nreq++;
            obs_prev_req = bus.vid_req;
            obs_prev_ack = ack_v;
            check("vid_req", {31'd0, bus.vid_req}, {31'd0, m_pend});
            if (m_pend) check("vid_addr", {11'd0, bus.vid_addr}, {11'd0, m_addr});
            check("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
        end
        de = 1'b0;
        bus.vid_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        resb = 1'b0; de = 1'b0; vsync_n = 1'b1;
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = 4'h0; bus.cpu_di = 8'h00;
        bus.vid_ack = 1'b0;
        ph = 2'd0; m_pend = 1'b0; m_cnt = 21'd0; m_addr = 21'd0; m_wait = 0;
        m_ovr = 1'b0; m_de_prev = 1'b0; m_off = 8'd0;
        b_hi = 6'd0; b_mid = 8'd0; b_lo = 7'd0;
        obs_nreq = 0; obs_prev_req = 1'b0; obs_prev_ack = 1'b0;

        // reset state
        tick(); tick();
        check("rst_req",   {31'd0, bus.vid_req}, 32'd0);
        check("rst_addr",  {11'd0, bus.vid_addr}, 32'd0);
        check("rst_ovr",   {31'd0, bus.overrun}, 32'd0);
        check("rst_cpudo", {24'd0, bus.cpu_do}, 32'd0);
        resb = 1'b1;
        ph = 2'd0;

        // base $01/$78, vsync pulse, counter reads back $01/$78/$00
        set_base(6'h01, 8'h78, 7'd0);
        vpulse();
        read_cnt("cnt_after_vload", 21'h00BC00);
        check("req_after_vload", {31'd0, bus.vid_req}, 32'd0);
        rd(4'h1, d);
        check("rd_base_hi", {24'd0, d}, 32'h01);
        rd(4'h3, d);
        check("rd_base_mid", {24'd0, d}, 32'h78);
        wr(4'h1, 8'h01);
        check("cpudo_hold", {24'd0, bus.cpu_do}, 32'h78);
        rd(4'hB, d);
        check("rd_unmapped", {24'd0, d}, 32'h00);

        // 32 clocks of de with same-cycle ack: 8 requests $BC00..$BC07
        align0();
        obs_nreq = 0;
        run(36, 32, 0);
        check("nreq_full_rate", obs_nreq, 32'd8);
        read_cnt("cnt_full_rate", 21'h00BC08);

        // ack withheld 6 cycles: overrun, single request, cleared by $5 read
        align0();
        obs_nreq = 0;
        run(12, 8, 6);
        check("nreq_overrun", obs_nreq, 32'd1);
        check("ovr_set", {31'd0, bus.overrun}, 32'd1);
        read_cnt("cnt_overrun", 21'h00BC09);
        check("ovr_cleared", {31'd0, bus.overrun}, 32'd0);

        // wrap: 128 fetches from $1FFF80 end at $000000
        set_base(6'h3F, 8'hFF, 7'd0);
        vpulse();
        align0();
        run(516, 512, 0);
        read_cnt("cnt_wrap", 21'h000000);

        // vload coincident with ack: counter = base, request dropped
        set_base(6'h00, 8'h12, 7'd0);
        align0();
        run(5, 4, 99);
        check("req_pending", {31'd0, bus.vid_req}, 32'd1);
        vsync_n = 1'b0;
        tick();
        bus.vid_ack = 1'b1;
        tick();
        bus.vid_ack = 1'b0;
        vsync_n = 1'b1;
        m_pend = 1'b0;
        m_cnt = {b_hi, b_mid, b_lo};
        check("req_drop_vload", {31'd0, bus.vid_req}, 32'd0);
        read_cnt("cnt_vload_ack", 21'h000900);

        // line offset: 4 fetches from $0 with $F = $10
        set_base(6'h00, 8'h00, 7'd0);
        wr(4'hF, 8'h10);
`ifdef VIDADDR_STE_SCROLL_EN
        m_off = 8'h10;
`else
        m_off = 8'h00;
`endif
        vpulse();
        align0();
        obs_nreq = 0;
        run(20, 16, 0);
        check("nreq_line", obs_nreq, 32'd4);
`ifdef VIDADDR_STE_SCROLL_EN
        read_cnt("cnt_line_offset", 21'h000014);
        rd(4'hF, d);
        check("rd_offset", {24'd0, d}, 32'h10);
`else
        read_cnt("cnt_line_offset", 21'h000004);
        rd(4'hF, d);
        check("rd_offset", {24'd0, d}, 32'h00);
`endif

        // randomized lines against the reference model
        for (int it = 0; it < 6; it++) begin
            int de_len, delay;
            logic [7:0] off;
            set_base(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
                     7'($urandom_range(0, 127)));
            off = 8'($urandom_range(0, 255));
            wr(4'hF, off);
`ifdef VIDADDR_STE_SCROLL_EN
            m_off = off;
`else
            m_off = 8'h00;
`endif
            vpulse();
            de_len = $urandom_range(4, 40);
            delay  = $urandom_range(0, 7);
            run(de_len + 12, de_len, delay);
            read_cnt("cnt_random", m_cnt);
        end

        // reset in the middle of a request drops it immediately
        set_base(6'h00, 8'h40, 7'd0);
        vpulse();
        align0();
        run(5, 4, 99);
        #2;
        resb = 1'b0;
        #1;
        check("rstmid_req",  {31'd0, bus.vid_req}, 32'd0);
        check("rstmid_addr", {11'd0, bus.vid_addr}, 32'd0);
        tick();
        resb = 1'b1;
        ph = 2'd0;
        m_pend = 1'b0; m_cnt = 21'd0; m_ovr = 1'b0; m_de_prev = 1'b0;
        b_hi = 6'd0; b_mid = 8'd0; b_lo = 7'd0;
        read_cnt("cnt_after_rst", 21'h000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
